// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: reset/NOP defaults, fetch state encoding,
// IF/ID register layout and the PC incrementer.
package fetch_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

   localparam int IFID_PC_W   = 32;
   localparam int IFID_INST_W = 32;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic                   valid;
      logic [IFID_PC_W-1:0]   pc;
      logic [IFID_PC_W-1:0]   pc_4;
      logic [IFID_INST_W-1:0] inst;
   } ifid_t;

   // Shared 32-bit adder; wraps modulo 2^32.
   function automatic logic [31:0] pc_add4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory req/ack port. The fetch stage is the master.
interface fetch_ctrl_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, addr, input  ack, rdata);
   modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_ctrl_ifid_reg.sv
// IF/ID pipeline register: flush outranks load, load outranks bubble,
// otherwise the contents hold.
module ifid_reg
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] ld_pc,
   input  logic [31:0] ld_inst,
   output ifid_t       q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '{valid: 1'b0, pc: '0, pc_4: '0, inst: NOP_INST};
      end else if (flush) begin
         q <= '{valid: 1'b0, pc: '0, pc_4: '0, inst: NOP_INST};
      end else if (load) begin
         q <= '{valid: 1'b1, pc: ld_pc, pc_4: pc_add4(ld_pc), inst: ld_inst};
      end else if (bubble) begin
         q.valid <= 1'b0;
         q.inst  <= NOP_INST;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem req/ack port,
// and feeds IF/ID through a one-entry skid buffer under stall and redirect.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [31:0]        branch_pc,
   fetch_ctrl_if.master       imem,
   output logic               ifid_valid,
   output logic [31:0]        ifid_pc,
   output logic [31:0]        ifid_pc_4,
   output logic [31:0]        ifid_inst
);

   fetch_state_t state, state_n;
   logic [31:0]  pc, pc_n;
   logic [31:0]  out_addr, out_addr_n;
   logic [31:0]  skid_pc, skid_pc_n;
   logic [31:0]  skid_inst, skid_inst_n;
   logic [31:0]  br_tgt;
   logic         xfer;
   logic         ld, fl, bub;
   logic [31:0]  ld_pc, ld_inst;
   ifid_t        ifid_q;

   assign br_tgt    = branch_pc & ~32'd3;
   assign imem.req  = !rst && (state != HOLD);
   // DISCARD keeps presenting the abandoned address until its ack drains.
   assign imem.addr = (state == DISCARD) ? out_addr : pc;
   assign xfer      = imem.req && imem.ack;

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      out_addr_n  = out_addr;
      skid_pc_n   = skid_pc;
      skid_inst_n = skid_inst;
      ld          = 1'b0;
      fl          = 1'b0;
      bub         = 1'b0;
      ld_pc       = pc;
      ld_inst     = imem.rdata;
      case (state)
         FETCH: begin
            if (branch_taken) begin
               pc_n        = br_tgt;
               fl          = 1'b1;
               skid_pc_n   = '0;
               skid_inst_n = '0;
               out_addr_n  = pc;
               if (!xfer) state_n = DISCARD;
            end else if (xfer && !stall) begin
               ld   = 1'b1;
               pc_n = pc_add4(pc);
            end else if (xfer) begin
               skid_pc_n   = pc;
               skid_inst_n = imem.rdata;
               pc_n        = pc_add4(pc);
               state_n     = HOLD;
            end else if (!stall) begin
               bub = 1'b1;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               pc_n        = br_tgt;
               fl          = 1'b1;
               skid_pc_n   = '0;
               skid_inst_n = '0;
               state_n     = FETCH;
            end else if (!stall) begin
               ld      = 1'b1;
               ld_pc   = skid_pc;
               ld_inst = skid_inst;
               state_n = FETCH;
            end
         end
         DISCARD: begin
            if (branch_taken) begin
               pc_n = br_tgt;
               fl   = 1'b1;
            end else if (!stall) begin
               bub = 1'b1;
            end
            if (xfer) state_n = FETCH;
         end
         default: state_n = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         out_addr  <= '0;
         skid_pc   <= '0;
         skid_inst <= '0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         out_addr  <= out_addr_n;
         skid_pc   <= skid_pc_n;
         skid_inst <= skid_inst_n;
      end
   end

   ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
      .clk     (clk),
      .rst     (rst),
      .flush   (fl),
      .load    (ld),
      .bubble  (bub),
      .ld_pc   (ld_pc),
      .ld_inst (ld_inst),
      .q       (ifid_q)
   );

   assign ifid_valid = ifid_q.valid;
   assign ifid_pc    = ifid_q.pc;
   assign ifid_pc_4  = ifid_q.pc_4;
   assign ifid_inst  = ifid_q.inst;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: random-latency imem, random stall and
// redirect; every instruction reaching IF/ID must follow program order.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_pc;
   logic        ifid_valid;
   logic [31:0] ifid_pc, ifid_pc_4, ifid_inst;

   fetch_ctrl_if imem ();

   fetch_ctrl #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_pc    (branch_pc),
      .imem         (imem),
      .ifid_valid   (ifid_valid),
      .ifid_pc      (ifid_pc),
      .ifid_pc_4    (ifid_pc_4),
      .ifid_inst    (ifid_inst)
   );

   initial forever #5 clk = ~clk;

   int          vectors   = 0;
   int          errors    = 0;
   int          delivered = 0;
   int          maxlat    = 0;
   bit          mon_en    = 1'b0;
   logic [31:0] exp_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory: random latency per request, data is a fixed function of address.
   initial begin
      int  wait_left;
      bit  busy;
      busy       = 1'b0;
      wait_left  = 0;
      imem.ack   = 1'b0;
      imem.rdata = '0;
      forever begin
         @(posedge clk); #3;
         if (rst || !imem.req) begin
            imem.ack = 1'b0;
            busy     = 1'b0;
         end else begin
            if (!busy) begin
               busy      = 1'b1;
               wait_left = $urandom_range(0, maxlat);
            end
            if (wait_left == 0) begin
               imem.ack   = 1'b1;
               imem.rdata = mem_word(imem.addr);
               busy       = 1'b0;
            end else begin
               imem.ack   = 1'b0;
               imem.rdata = $urandom;
               wait_left--;
            end
         end
      end
   end

   // Monitor: sample 1 time unit after each edge; stall/ack still show the
   // values seen at that edge, req/addr/IF/ID show post-edge values.
   initial begin
      logic        prev_v, prev_req;
      logic [31:0] prev_addr, prev_pc, exp_pc;
      prev_v = 1'b0; prev_req = 1'b0; prev_addr = '0; prev_pc = '0;
      forever begin
         @(posedge clk); #1;
         if (rst || !mon_en) begin
            prev_v   = 1'b0;
            prev_req = 1'b0;
         end else begin
            if (prev_req && !imem.ack) begin
               check("req_held", {31'd0, imem.req}, 32'd1);
               check("addr_stable", imem.addr, prev_addr);
            end
            if (!ifid_valid) begin
               check("bubble_inst", ifid_inst, NOP);
            end else if (!prev_v || !stall) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  errors++;
                  $display("FAIL unexpected_inst: got pc %h expected none", ifid_pc);
               end else begin
                  exp_pc = exp_q.pop_front();
                  check("ifid_pc", ifid_pc, exp_pc);
                  check("ifid_pc_4", ifid_pc_4, exp_pc + 32'd4);
                  check("ifid_inst", ifid_inst, mem_word(exp_pc));
                  exp_q.push_back(exp_pc + 32'd4);
                  delivered++;
               end
            end else begin
               check("held_pc", ifid_pc, prev_pc);
            end
            prev_v    = ifid_valid;
            prev_pc   = ifid_pc;
            prev_req  = imem.req;
            prev_addr = imem.addr;
         end
      end
   end

   task automatic step(input bit st, input bit br, input logic [31:0] bpc);
      @(posedge clk); #3;
      stall        = st;
      branch_taken = br;
      branch_pc    = bpc;
      if (br) begin
         exp_q.delete();
         exp_q.push_back(bpc & ~32'd3);
      end
   endtask

   initial begin
      int          d0;
      logic [31:0] tgt;
      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_pc = '0;
      #1;
      check("rst_req", {31'd0, imem.req}, 32'd0);
      check("rst_valid", {31'd0, ifid_valid}, 32'd0);
      check("rst_inst", ifid_inst, NOP);
      check("rst_pc", ifid_pc, 32'd0);
      check("rst_pc_4", ifid_pc_4, 32'd0);
      exp_q.push_back(RPC);
      mon_en = 1'b1;
      @(posedge clk); @(posedge clk); #4;
      rst = 1'b0;
      #1;
      check("post_rst_addr", imem.addr, RPC);
      check("post_rst_req", {31'd0, imem.req}, 32'd1);

      // Zero-wait memory: one instruction per cycle once streaming.
      maxlat = 0;
      repeat (4) step(0, 0, 0);
      d0 = delivered;
      repeat (8) step(0, 0, 0);
      check("zero_wait_rate", delivered - d0, 32'd8);

      // Multi-cycle latency without stall.
      maxlat = 3;
      repeat (30) step(0, 0, 0);

      // Random stall / redirect / latency.
      for (int i = 0; i < 1500; i++) begin
         if (i % 100 == 0) maxlat = $urandom_range(0, 3);
         case ($urandom_range(0, 2))
            0:       tgt = $urandom;
            1:       tgt = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            default: tgt = $urandom_range(0, 255);
         endcase
         step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, tgt);
      end

      // PC wrap through 0xFFFF_FFFC; low branch bits must be ignored.
      maxlat = 0;
      step(0, 1, 32'hFFFF_FFF6);
      repeat (8) step(0, 0, 0);

      // Reset in the middle of an outstanding request.
      maxlat = 6;
      repeat (3) step(0, 0, 0);
      @(posedge clk); #4;
      rst = 1'b1;
      #1;
      check("rst_mid_req", {31'd0, imem.req}, 32'd0);
      exp_q.delete();
      exp_q.push_back(RPC);
      @(posedge clk); @(posedge clk); #4;
      rst = 1'b0;
      #1;
      check("rst_mid_addr", imem.addr, RPC);
      check("rst_mid_valid", {31'd0, ifid_valid}, 32'd0);
      maxlat = 0;
      repeat (12) step(0, 0, 0);

      check("liveness", {31'd0, delivered >= 300}, 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
